// File: rtl/bram_rd_arbiter.sv
// Round-robin read arbiter for the shared BRAM read port.
// Two requesters each present a level request with an address. The arbiter
// issues one read at a time on m_enb/m_raddr, waits for the wrapper's
// m_valid pulse, and returns the registered data to the requester that won.
// Ports:
//   clk, rst            clock; asynchronous active-low reset
//   req0/1, addr0/1     client read requests and their addresses
//   gnt0/1              pulse in the cycle the read is issued to the BRAM
//   rvalid0/1, rdata    one-cycle completion pulse and shared read data
//   bram_we             wrapper write enable (issue is deferred while high)
//   m_enb, m_raddr      wrapper read enable and registered read address
//   m_valid, m_dout     wrapper read completion and data
//   busy, err           transaction in progress; sticky read-timeout flag
module bram_rd_arbiter #(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned TIMEOUT    = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0,
    input  logic                  req1,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [ADDR_WIDTH-1:0] addr1,
    output logic                  gnt0,
    output logic                  gnt1,
    output logic                  rvalid0,
    output logic                  rvalid1,
    output logic [DATA_WIDTH-1:0] rdata,
    input  logic                  bram_we,
    output logic                  m_enb,
    output logic [ADDR_WIDTH-1:0] m_raddr,
    input  logic                  m_valid,
    input  logic [DATA_WIDTH-1:0] m_dout,
    output logic                  busy,
    output logic                  err
);

    localparam int unsigned TCNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic                sel;
    logic                prio;
    logic                win_c;
    logic [TCNT_W-1:0]   tcnt;
    logic                tmo_c;

    // On a tie the prio bit picks the winner; a lone requester always wins.
    assign win_c = (req0 && req1) ? prio : req1;
    assign tmo_c = (tcnt == TCNT_W'(TIMEOUT));

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and state-decoded strobes
    always_comb begin
        state_nxt = state;
        m_enb     = 1'b0;
        gnt0      = 1'b0;
        gnt1      = 1'b0;
        rvalid0   = 1'b0;
        rvalid1   = 1'b0;
        busy      = (state != IDLE);
        case (state)
            IDLE: begin
                if (req0 || req1) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                // A write in progress holds the read back without granting.
                m_enb = !bram_we;
                gnt0  = !bram_we && !sel;
                gnt1  = !bram_we && sel;
                if (!bram_we) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (m_valid) begin
                    state_nxt = DONE;
                end else if (tmo_c) begin
                    state_nxt = IDLE;
                end
            end
            DONE: begin
                rvalid0   = !sel;
                rvalid1   = sel;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Address/winner latch, timeout counter, data capture, priority and error
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sel     <= 1'b0;
            prio    <= 1'b0;
            m_raddr <= '0;
            tcnt    <= '0;
            rdata   <= '0;
            err     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        sel     <= win_c;
                        m_raddr <= win_c ? addr1 : addr0;
                    end
                end
                ISSUE: begin
                    // First WAIT cycle counts as 1.
                    if (!bram_we) begin
                        tcnt <= TCNT_W'(1);
                    end
                end
                WAIT: begin
                    if (m_valid) begin
                        rdata <= m_dout;
                    end else if (tmo_c) begin
                        err  <= 1'b1;
                        prio <= ~sel;
                    end else begin
                        tcnt <= tcnt + TCNT_W'(1);
                    end
                end
                DONE: begin
                    prio <= ~sel;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bram_rd_arbiter.sv
// Randomized bench for bram_rd_arbiter against a transaction-level model.
module tb_bram_rd_arbiter;

    localparam int unsigned AW = 16;
    localparam int unsigned DW = 32;
    localparam int unsigned TO = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          req0, req1;
    logic [AW-1:0] addr0, addr1;
    logic          gnt0, gnt1, rvalid0, rvalid1;
    logic [DW-1:0] rdata;
    logic          bram_we;
    logic          m_enb;
    logic [AW-1:0] m_raddr;
    logic          m_valid;
    logic [DW-1:0] m_dout;
    logic          busy, err;

    bram_rd_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .addr0(addr0), .addr1(addr1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata(rdata), .bram_we(bram_we), .m_enb(m_enb), .m_raddr(m_raddr),
        .m_valid(m_valid), .m_dout(m_dout), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] ctl_obs();
        return 32'({busy, m_enb, gnt0, gnt1, rvalid0, rvalid1, err});
    endfunction

    function automatic logic [31:0] ctl_exp(input logic b, input logic en, input logic g0,
                                            input logic g1, input logic v0, input logic v1,
                                            input logic e);
        return 32'({b, en, g0, g1, v0, v1, e});
    endfunction

    // Wrapper stand-in: read latency of two cycles, optionally dropping reads.
    logic [DW-1:0] mem [16];
    bit            v1, v2;
    logic [AW-1:0] a1;
    logic [DW-1:0] d2;
    bit            reliable;
    logic          stray;
    logic [DW-1:0] junk;

    always @(posedge clk) begin
        v1 <= m_enb && (reliable || ($urandom_range(7) != 0));
        a1 <= m_raddr;
        v2 <= v1;
        d2 <= mem[a1[3:0]];
    end

    assign m_valid = v2 | stray;
    assign m_dout  = v2 ? d2 : junk;

    // Reference model: walks each transaction as a sequence of cycles.
    bit model_on;

    initial begin : ref_model
        logic          mp;
        logic [DW-1:0] mr;
        logic          me;
        int            win;
        logic [AW-1:0] a;
        bit            ok;
        mp = 1'b0;
        mr = '0;
        me = 1'b0;
        wait (model_on);
        while (model_on) begin
            @(negedge clk);
            check("idle_ctl", ctl_obs(), ctl_exp(0, 0, 0, 0, 0, 0, me));
            check("idle_rdata", rdata, mr);
            if (req0 || req1) begin
                win = (req0 && req1) ? int'(mp) : (req1 ? 1 : 0);
                a   = (win == 1) ? addr1 : addr0;
                do begin
                    @(negedge clk);
                    check("issue_ctl", ctl_obs(),
                          ctl_exp(1, !bram_we, (win == 0) && !bram_we, (win == 1) && !bram_we, 0, 0, me));
                    check("issue_raddr", 32'(m_raddr), 32'(a));
                end while (bram_we);
                ok = 1'b0;
                for (int k = 1; k <= int'(TO); k++) begin
                    @(negedge clk);
                    check("wait_ctl", ctl_obs(), ctl_exp(1, 0, 0, 0, 0, 0, me));
                    check("wait_raddr", 32'(m_raddr), 32'(a));
                    check("wait_rdata", rdata, mr);
                    if (m_valid) begin
                        mr = m_dout;
                        ok = 1'b1;
                        break;
                    end
                    if (k == int'(TO)) begin
                        me = 1'b1;
                        mp = (win == 0);
                    end
                end
                if (ok) begin
                    @(negedge clk);
                    check("done_ctl", ctl_obs(), ctl_exp(1, 0, 0, 0, win == 0, win == 1, me));
                    check("done_rdata", rdata, mr);
                    mp = (win == 0);
                end
            end
        end
    end

    initial begin : main
        logic g0, g1;
        bit   got;
        rst = 1'b0; req0 = 1'b0; req1 = 1'b0; addr0 = '0; addr1 = '0;
        bram_we = 1'b0; stray = 1'b0; junk = '0; reliable = 1'b1;
        for (int i = 0; i < 16; i++) mem[i] = $urandom;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_ctl", ctl_obs(), 32'd0);
        check("reset_rdata", rdata, 32'd0);
        check("reset_raddr", 32'(m_raddr), 32'd0);

        @(posedge clk);
        #1 rst = 1'b1;
        reliable = 1'b0;
        model_on = 1'b1;

        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            g0 = gnt0;
            g1 = gnt1;
            @(posedge clk);
            #1;
            if (!req0) begin
                if ($urandom_range(1) == 1) begin
                    req0  = 1'b1;
                    addr0 = AW'($urandom_range(15));
                end
            end else if (g0) begin
                req0  = ($urandom_range(1) == 1);
                addr0 = AW'($urandom_range(15));
            end
            if (!req1) begin
                if ($urandom_range(1) == 1) begin
                    req1  = 1'b1;
                    addr1 = AW'($urandom_range(15));
                end
            end else if (g1) begin
                req1  = ($urandom_range(1) == 1);
                addr1 = AW'($urandom_range(15));
            end
            bram_we = ($urandom_range(3) == 0);
            stray   = ($urandom_range(15) == 0);
            junk    = $urandom;
        end

        // Drain: let outstanding requests complete, raise no new ones.
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            g0 = gnt0;
            g1 = gnt1;
            @(posedge clk);
            #1;
            if (g0) req0 = 1'b0;
            if (g1) req1 = 1'b0;
            bram_we = 1'b0;
            stray   = 1'b0;
        end
        model_on = 1'b0;
        repeat (3) @(posedge clk);

        // Reset in the first WAIT cycle; the stale valid must be ignored.
        #1 reliable = 1'b1;
        req0  = 1'b1;
        addr0 = 16'h0003;
        got   = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (gnt0) begin
                got = 1'b1;
                break;
            end
        end
        check("rst_gnt_seen", 32'(got), 32'd1);
        @(posedge clk);
        #1 req0 = 1'b0;
        rst = 1'b0;
        #1;
        check("rst_ctl", ctl_obs(), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_raddr", 32'(m_raddr), 32'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("post_rst_ctl", ctl_obs(), 32'd0);
            check("post_rst_rdata", rdata, 32'd0);
        end

        // Stray valid while idle.
        @(posedge clk);
        #1 stray = 1'b1;
        junk = 32'h0000_0055;
        @(negedge clk);
        check("stray_ctl", ctl_obs(), 32'd0);
        @(posedge clk);
        #1 stray = 1'b0;
        @(negedge clk);
        check("stray_after_ctl", ctl_obs(), 32'd0);
        check("stray_rdata", rdata, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_bad);
        $finish;
    end

endmodule
